// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP controller with a parametrised IR and IDCODE / BYPASS / USER data registers.
// state | meaning: TLR reset-idle, RTI run-idle, SEL_x select, CAP_x capture, SH_x shift,
//       EX1_x/EX2_x exit, PAU_x pause, UPD_x update (x = DR or IR)
module jtag_tap_param #(
  parameter int unsigned       IR_W         = 4,
  parameter logic [31:0]       IDCODE_VAL   = 32'h000FAF01,
  parameter logic [IR_W-1:0]   IDCODE_INSTR = IR_W'(4'b1110),
  parameter logic [IR_W-1:0]   USER_INSTR   = IR_W'(4'b1010),
  parameter int unsigned       USER_DR_W    = 8
) (
  input  logic                 tck,
  input  logic                 trst_n,
  input  logic                 enable,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_en,
  output logic [3:0]           tap_state,
  output logic [IR_W-1:0]      ir_value,
  input  logic [USER_DR_W-1:0] user_capture,
  output logic [USER_DR_W-1:0] user_dr,
  output logic                 user_update
);

  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_state_t;

  localparam logic [IR_W-1:0]      IR_CAP   = IR_W'(2'b01);
  localparam logic [USER_DR_W-1:0] USER_MSB = USER_DR_W'(1) << (USER_DR_W - 1);

  tap_state_t            state;
  tap_state_t            state_nxt;
  logic [IR_W-1:0]       ir_sr;
  logic [31:0]           idcode_sr;
  logic                  bypass_sr;
  logic [USER_DR_W-1:0]  user_sr;
  logic                  sel_idcode;
  logic                  sel_user;
  logic                  dr_lsb;

  function automatic tap_state_t next_of(input tap_state_t s, input logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      UPD_IR: return m ? SEL_DR : RTI;
      default: return TLR;
    endcase
  endfunction

  assign state_nxt  = enable ? next_of(state, tms) : TLR;
  assign tap_state  = state;
  // IDCODE wins if both opcodes were configured identical
  assign sel_idcode = (ir_value == IDCODE_INSTR);
  assign sel_user   = (ir_value == USER_INSTR) && !sel_idcode;
  assign dr_lsb     = sel_idcode ? idcode_sr[0] : (sel_user ? user_sr[0] : bypass_sr);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state       <= TLR;
      ir_value    <= IDCODE_INSTR;
      ir_sr       <= '0;
      idcode_sr   <= '0;
      bypass_sr   <= 1'b0;
      user_sr     <= '0;
      user_dr     <= '0;
      user_update <= 1'b0;
    end else begin
      state       <= state_nxt;
      user_update <= 1'b0;
      if (state_nxt == TLR)
        ir_value <= IDCODE_INSTR;
      else if (state == UPD_IR)
        ir_value <= ir_sr;
      case (state)
        CAP_IR: ir_sr <= IR_CAP;
        SH_IR:  ir_sr <= {tdi, ir_sr[IR_W-1:1]};
        CAP_DR: begin
          if (sel_idcode)    idcode_sr <= IDCODE_VAL;
          else if (sel_user) user_sr   <= user_capture;
          else               bypass_sr <= 1'b0;
        end
        SH_DR: begin
          if (sel_idcode)    idcode_sr <= {tdi, idcode_sr[31:1]};
          else if (sel_user) user_sr   <= (user_sr >> 1) | (tdi ? USER_MSB : '0);
          else               bypass_sr <= tdi;
        end
        UPD_DR: begin
          if (sel_user) begin
            user_dr     <= user_sr;
            user_update <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // tdo/tdo_en launch on the falling edge so the probe samples a settled bit
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else begin
      tdo_en <= (state == SH_IR) || (state == SH_DR);
      if (state == SH_IR)      tdo <= ir_sr[0];
      else if (state == SH_DR) tdo <= dr_lsb;
      else                     tdo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Randomised bench for jtag_tap_param against a queue-based TAP model, plus fixed scans.
module tb_jtag_tap_param;
  localparam int          IR_W   = 4;
  localparam int          UW     = 8;
  localparam logic [31:0] IDC    = 32'h000FAF01;
  localparam logic [3:0]  I_ID   = 4'hE;
  localparam logic [3:0]  I_USER = 4'hA;

  logic tck = 1'b0;
  logic trst_n, enable, tms, tdi, tdo, tdo_en, user_update;
  logic [3:0] tap_state, ir_value;
  logic [7:0] user_capture, user_dr;

  jtag_tap_param #(
    .IR_W(IR_W), .IDCODE_VAL(IDC), .IDCODE_INSTR(I_ID),
    .USER_INSTR(I_USER), .USER_DR_W(UW)
  ) dut (
    .tck(tck), .trst_n(trst_n), .enable(enable), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .ir_value(ir_value),
    .user_capture(user_capture), .user_dr(user_dr), .user_update(user_update)
  );

  always #5 tck = ~tck;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // next-state tables indexed by state code, from the TAP transition list
  int nx0[16];
  int nx1[16];

  int         m_state;
  logic [3:0] m_ir;
  bit         m_ir_q[$];
  bit         m_dr_q[$];
  logic [7:0] m_user_dr;
  bit         m_upd, m_tdo, m_tdo_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 15;
    m_ir = I_ID;
    m_ir_q.delete();
    m_dr_q.delete();
    m_user_dr = 8'h00;
    m_upd = 0;
    m_tdo = 0;
    m_tdo_en = 0;
  endtask

  task automatic m_step();
    int cur, nxt;
    cur = m_state;
    nxt = enable ? (tms ? nx1[cur] : nx0[cur]) : 15;
    m_upd = 0;
    case (cur)
      14: begin
        m_ir_q.delete();
        m_ir_q.push_back(1'b1);
        for (int i = 1; i < IR_W; i++) m_ir_q.push_back(1'b0);
      end
      10: if (m_ir_q.size() > 0) begin
        void'(m_ir_q.pop_front());
        m_ir_q.push_back(tdi);
      end
      6: begin
        m_dr_q.delete();
        if (m_ir == I_ID)        for (int i = 0; i < 32; i++) m_dr_q.push_back(IDC[i]);
        else if (m_ir == I_USER) for (int i = 0; i < UW; i++) m_dr_q.push_back(user_capture[i]);
        else                     m_dr_q.push_back(1'b0);
      end
      2: if (m_dr_q.size() > 0) begin
        void'(m_dr_q.pop_front());
        m_dr_q.push_back(tdi);
      end
      5: if (m_ir == I_USER) begin
        m_user_dr = 8'h00;
        foreach (m_dr_q[i]) if (i < UW) m_user_dr[i] = m_dr_q[i];
        m_upd = 1;
      end
      13: foreach (m_ir_q[i]) if (i < IR_W) m_ir[i] = m_ir_q[i];
      default: ;
    endcase
    if (nxt == 15) m_ir = I_ID;
    m_state = nxt;
    m_tdo_en = (nxt == 2) || (nxt == 10);
    m_tdo = 0;
    if (nxt == 2 && m_dr_q.size() > 0)  m_tdo = m_dr_q[0];
    if (nxt == 10 && m_ir_q.size() > 0) m_tdo = m_ir_q[0];
  endtask

  always @(posedge tck) if (trst_n) m_step();

  always @(negedge tck) begin
    #2;
    if (chk_en) begin
      chk("tap_state",   {28'h0, tap_state},   m_state);
      chk("ir_value",    {28'h0, ir_value},    {28'h0, m_ir});
      chk("tdo",         {31'h0, tdo},         {31'h0, m_tdo});
      chk("tdo_en",      {31'h0, tdo_en},      {31'h0, m_tdo_en});
      chk("user_dr",     {24'h0, user_dr},     {24'h0, m_user_dr});
      chk("user_update", {31'h0, user_update}, {31'h0, m_upd});
    end
  end

  task automatic cyc(input bit t, input bit d);
    tms = t;
    tdi = d;
    @(negedge tck);
    #3;
  endtask

  task automatic reset_pulse();
    trst_n = 1'b0;
    m_reset();
    cyc(1, 0);
    cyc(1, 0);
    trst_n = 1'b1;
  endtask

  task automatic goto_ir_shift();
    cyc(1, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
  endtask

  task automatic goto_dr_shift();
    cyc(1, 0); cyc(0, 0); cyc(0, 0);
  endtask

  // called in a shift state: n bits out/in, then update and two idle cycles
  task automatic scan(input int n, input logic [31:0] din, output logic [31:0] dout, output int nupd);
    dout = 32'h0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      cyc(i == n - 1, din[i]);
    end
    nupd = 0;
    cyc(1, 0); nupd += int'(user_update);
    cyc(0, 0); nupd += int'(user_update);
    cyc(0, 0); nupd += int'(user_update);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, din;
    int n, nu;
    nx0 = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    nx1 = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};
    trst_n = 1'b0; enable = 1'b1; tms = 1'b1; tdi = 1'b0; user_capture = 8'h00;
    m_reset();
    @(negedge tck); #3;
    chk("rst_state",  {28'h0, tap_state}, 32'hF);
    chk("rst_ir",     {28'h0, ir_value},  32'hE);
    chk("rst_tdo",    {31'h0, tdo},       32'h0);
    chk("rst_tdo_en", {31'h0, tdo_en},    32'h0);
    chk("rst_udr",    {24'h0, user_dr},   32'h0);
    chk("rst_upd",    {31'h0, user_update}, 32'h0);
    trst_n = 1'b1;
    chk_en = 1'b1;

    // five tms=1 from every state
    for (int s = 0; s < 16; s++) begin
      int budget = 0;
      while (m_state != s && budget < 2000) begin
        cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        budget++;
      end
      chk("walk_reach", {28'h0, tap_state}, s);
      repeat (5) cyc(1, 0);
      chk("tms5_tlr", {28'h0, tap_state}, 32'hF);
    end

    // IDCODE read straight out of reset
    reset_pulse();
    cyc(0, 0); cyc(1, 0); cyc(0, 0); cyc(0, 0);
    scan(32, 32'h0, d, n);
    chk("idcode", d, 32'h000FAF01);

    // IR capture pattern, then BYPASS
    goto_ir_shift();
    scan(4, 32'hF, d, n);
    chk("ir_cap_out", d, 32'h1);
    chk("ir_all_ones", {28'h0, ir_value}, 32'hF);
    goto_dr_shift();
    din = $urandom;
    scan(16, din, d, n);
    chk("bypass_delay", d, (din << 1) & 32'hFFFF);
    chk("bypass_no_upd", n, 0);

    // USER register
    user_capture = 8'hA5;
    goto_ir_shift();
    scan(4, {28'h0, I_USER}, d, n);
    chk("ir_user", {28'h0, ir_value}, {28'h0, I_USER});
    goto_dr_shift();
    scan(8, 32'h3C, d, n);
    chk("user_tdo", d, 32'hA5);
    chk("user_dr_3c", {24'h0, user_dr}, 32'h3C);
    chk("user_upd_once", n, 1);
    user_capture = 8'h5A;
    goto_dr_shift();
    scan(12, 32'hABC, d, n);
    chk("user_long_tdo", d, 32'hC5A);
    chk("user_long_dr", {24'h0, user_dr}, 32'hAB);
    user_capture = 8'hE7;
    goto_dr_shift();
    scan(5, 32'h13, d, n);
    chk("user_short_tdo", d, 32'h07);
    chk("user_short_dr", {24'h0, user_dr}, 32'h9F);

    // reset in the middle of a USER shift
    reset_pulse();
    cyc(0, 0);
    user_capture = 8'h66;
    goto_ir_shift();
    scan(4, {28'h0, I_USER}, d, n);
    goto_dr_shift();
    cyc(0, 1); cyc(0, 0); cyc(0, 1);
    trst_n = 1'b0;
    m_reset();
    nu = 0;
    cyc(1, 0); nu += int'(user_update);
    chk("abort_state", {28'h0, tap_state}, 32'hF);
    chk("abort_ir",    {28'h0, ir_value},  32'hE);
    chk("abort_udr",   {24'h0, user_dr},   32'h0);
    trst_n = 1'b1;
    cyc(0, 0); nu += int'(user_update);
    cyc(0, 0); nu += int'(user_update);
    chk("abort_no_upd", nu, 0);

    // enable dropped during Shift-DR
    goto_dr_shift();
    cyc(0, 1);
    enable = 1'b0;
    cyc(0, 0);
    chk("disable_state",  {28'h0, tap_state}, 32'hF);
    chk("disable_tdo_en", {31'h0, tdo_en},    32'h0);
    chk("disable_ir",     {28'h0, ir_value},  32'hE);
    enable = 1'b1;

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset_pulse();
      end else begin
        if ((k % 16) == 0) user_capture = 8'($urandom);
        enable = (m_state != 5 && m_state != 13 && $urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
        cyc(($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)));
      end
    end
    enable = 1'b1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
